// File: rtl/cross_bar_pkg.sv
// Shared cross-bar types and constants: bus widths, slave-port FSM states,
// the timeout read-data pattern and the slave-select decode helper.
package cross_bar_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int SLAVE_W = 2;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } slave_port_state_t;

    localparam data_t TIMEOUT_DATA = 32'hDEAD_BEEF;

    // The top SLAVE_W address bits pick the target slave.
    function automatic logic [SLAVE_W-1:0] slave_sel(input addr_t addr);
        return addr[ADDR_W-1 -: SLAVE_W];
    endfunction

endpackage

// File: rtl/cross_bar_slave_port_rr_arbiter.sv
// Combinational round-robin arbiter: returns the first eligible index at or
// after ptr (mod N), plus a valid flag when any request is eligible.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         i_eligible,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [$clog2(N)-1:0] o_grant,
    output logic                 o_valid
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] w_idx [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign w_idx[gi] = IDX_W'((int'(i_ptr) + gi) % N);
    end

    // Scan from the farthest candidate down so the closest one to ptr wins.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_eligible[w_idx[k]]) begin
                o_grant = w_idx[k];
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cross_bar_slave_port.sv
// Per-slave cross-bar output stage: decode, round-robin arbitration, request
// forwarding and ack/rdata return. Optional BUSY timeout: CROSS_BAR_SLAVE_TIMEOUT_EN.
module cross_bar_slave_port
    import cross_bar_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int SLAVE_ID  = 0,
    parameter int TIMEOUT   = 16
) (
    input  logic                             clk,
    input  logic                             aresetn,
    input  logic [N_MASTERS-1:0]             master_req,
    input  logic [N_MASTERS-1:0][ADDR_W-1:0] master_addr,
    input  logic [N_MASTERS-1:0]             master_cmd,
    input  logic [N_MASTERS-1:0][DATA_W-1:0] master_wdata,
    output logic [N_MASTERS-1:0]             master_ack,
    output logic [DATA_W-1:0]                master_rdata,
    output logic                             slave_req,
    output logic [ADDR_W-1:0]                slave_addr,
    output logic                             slave_cmd,
    output logic [DATA_W-1:0]                slave_wdata,
    input  logic                             slave_ack,
    input  logic [DATA_W-1:0]                slave_rdata
`ifdef CROSS_BAR_SLAVE_TIMEOUT_EN
    ,
    output logic                             timeout_err
`endif
);

    localparam int PTR_W = $clog2(N_MASTERS);

    slave_port_state_t      r_state, w_state_next;
    logic [PTR_W-1:0]       r_ptr, w_ptr_next;
    logic [PTR_W-1:0]       r_grant, w_grant_next;
    logic                   r_slave_req, w_slave_req_next;
    addr_t                  r_slave_addr, w_slave_addr_next;
    logic                   r_slave_cmd, w_slave_cmd_next;
    data_t                  r_slave_wdata, w_slave_wdata_next;
    logic [N_MASTERS-1:0]   r_master_ack, w_master_ack_next;
    data_t                  r_master_rdata, w_master_rdata_next;

    logic [N_MASTERS-1:0]   w_eligible;
    logic [PTR_W-1:0]       w_arb_grant;
    logic                   w_arb_valid;

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_elig
        assign w_eligible[gi] = master_req[gi] &&
                                (slave_sel(master_addr[gi]) == SLAVE_W'(SLAVE_ID));
    end

    rr_arbiter #(
        .N (N_MASTERS)
    ) u_arb (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_grant    (w_arb_grant),
        .o_valid    (w_arb_valid)
    );

`ifdef CROSS_BAR_SLAVE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_timeout_err, w_timeout_err_next;
`else
    // TIMEOUT only matters when the timeout counter is built.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    always_comb begin
        w_state_next        = r_state;
        w_ptr_next          = r_ptr;
        w_grant_next        = r_grant;
        w_slave_req_next    = r_slave_req;
        w_slave_addr_next   = r_slave_addr;
        w_slave_cmd_next    = r_slave_cmd;
        w_slave_wdata_next  = r_slave_wdata;
        w_master_ack_next   = '0;
        w_master_rdata_next = r_master_rdata;
`ifdef CROSS_BAR_SLAVE_TIMEOUT_EN
        w_cnt_next          = r_cnt;
        w_timeout_err_next  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_grant_next       = w_arb_grant;
                    w_slave_addr_next  = master_addr[w_arb_grant];
                    w_slave_cmd_next   = master_cmd[w_arb_grant];
                    w_slave_wdata_next = master_wdata[w_arb_grant];
                    w_slave_req_next   = 1'b1;
                    w_ptr_next         = (w_arb_grant == PTR_W'(N_MASTERS - 1)) ?
                                         '0 : w_arb_grant + PTR_W'(1);
                    w_state_next       = BUSY;
`ifdef CROSS_BAR_SLAVE_TIMEOUT_EN
                    w_cnt_next         = '0;
`endif
                end
            end
            BUSY: begin
                if (slave_ack) begin
                    w_master_ack_next[r_grant] = 1'b1;
                    if (!r_slave_cmd) begin
                        w_master_rdata_next = slave_rdata;
                    end
                    w_slave_req_next = 1'b0;
                    w_state_next     = GAP;
                end
`ifdef CROSS_BAR_SLAVE_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_master_ack_next[r_grant] = 1'b1;
                    w_master_rdata_next        = TIMEOUT_DATA;
                    w_timeout_err_next         = 1'b1;
                    w_slave_req_next           = 1'b0;
                    w_state_next               = GAP;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
`endif
            end
            // The slave acks once more for the last req-high edge; drop it here.
            GAP: begin
                w_slave_req_next = 1'b0;
                w_state_next     = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state        <= IDLE;
            r_ptr          <= '0;
            r_grant        <= '0;
            r_slave_req    <= 1'b0;
            r_slave_addr   <= '0;
            r_slave_cmd    <= 1'b0;
            r_slave_wdata  <= '0;
            r_master_ack   <= '0;
            r_master_rdata <= '0;
`ifdef CROSS_BAR_SLAVE_TIMEOUT_EN
            r_cnt          <= '0;
            r_timeout_err  <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_next;
            r_ptr          <= w_ptr_next;
            r_grant        <= w_grant_next;
            r_slave_req    <= w_slave_req_next;
            r_slave_addr   <= w_slave_addr_next;
            r_slave_cmd    <= w_slave_cmd_next;
            r_slave_wdata  <= w_slave_wdata_next;
            r_master_ack   <= w_master_ack_next;
            r_master_rdata <= w_master_rdata_next;
`ifdef CROSS_BAR_SLAVE_TIMEOUT_EN
            r_cnt          <= w_cnt_next;
            r_timeout_err  <= w_timeout_err_next;
`endif
        end
    end

    assign master_ack   = r_master_ack;
    assign master_rdata = r_master_rdata;
    assign slave_req    = r_slave_req;
    assign slave_addr   = r_slave_addr;
    assign slave_cmd    = r_slave_cmd;
    assign slave_wdata  = r_slave_wdata;
`ifdef CROSS_BAR_SLAVE_TIMEOUT_EN
    assign timeout_err  = r_timeout_err;
`endif

endmodule

// File: tb/tb_cross_bar_slave_port.sv
// Directed self-checking bench for cross_bar_slave_port with a small
// registered-ack memory slave; optional timeout case under CROSS_BAR_SLAVE_TIMEOUT_EN.
module tb_cross_bar_slave_port;
    import cross_bar_pkg::*;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [1:0]        master_req;
    logic [1:0][31:0]  master_addr;
    logic [1:0]        master_cmd;
    logic [1:0][31:0]  master_wdata;
    logic [1:0]        master_ack;
    logic [31:0]       master_rdata;
    logic              slave_req;
    logic [31:0]       slave_addr;
    logic              slave_cmd;
    logic [31:0]       slave_wdata;
    logic              slave_ack = 1'b0;
    logic [31:0]       slave_rdata;
    logic              tie_ack0;
`ifdef CROSS_BAR_SLAVE_TIMEOUT_EN
    logic              timeout_err;
    int                terr_cnt = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int ack0_cnt = 0;
    int sreq_cnt = 0;
    int bad_cnt  = 0;
    int multi_cnt = 0;

    localparam logic [31:0] BAD_ADDR = 32'h4000_0008;

    always #5 clk = ~clk;

    cross_bar_slave_port #(
        .N_MASTERS (2),
        .SLAVE_ID  (0),
        .TIMEOUT   (16)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .master_req   (master_req),
        .master_addr  (master_addr),
        .master_cmd   (master_cmd),
        .master_wdata (master_wdata),
        .master_ack   (master_ack),
        .master_rdata (master_rdata),
        .slave_req    (slave_req),
        .slave_addr   (slave_addr),
        .slave_cmd    (slave_cmd),
        .slave_wdata  (slave_wdata),
        .slave_ack    (slave_ack),
        .slave_rdata  (slave_rdata)
`ifdef CROSS_BAR_SLAVE_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    // Slave: registered ack follows req by one cycle; memory preloaded in reset.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        slave_ack <= slave_req && !tie_ack0;
        if (!aresetn) begin
            mem[0] <= 32'hCAFE_0000;
            mem[1] <= 32'h1234_5678;
            mem[2] <= 32'h5555_0002;
        end else if (slave_req && slave_cmd) begin
            mem[slave_addr[5:2]] <= slave_wdata;
        end
    end
    assign slave_rdata = mem[slave_addr[5:2]];

    always @(negedge clk) begin
        if (master_ack[0]) ack0_cnt <= ack0_cnt + 1;
        if (slave_req) sreq_cnt <= sreq_cnt + 1;
        if (slave_req && slave_addr == BAD_ADDR) bad_cnt <= bad_cnt + 1;
        if ($countones(master_ack) > 1) multi_cnt <= multi_cnt + 1;
`ifdef CROSS_BAR_SLAVE_TIMEOUT_EN
        if (timeout_err) terr_cnt <= terr_cnt + 1;
`endif
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        aresetn = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_txn(input int m, input logic [31:0] a, input logic c,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
        int lat;
        int sreq0;
        lat = 0;
        @(negedge clk);
        master_req[m]   = 1'b1;
        master_addr[m]  = a;
        master_cmd[m]   = c;
        master_wdata[m] = wd;
        sreq0 = sreq_cnt;
        while (master_ack == 2'b00 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd3);
        check({tag, "_ack"}, 64'(master_ack), 64'(2'b01 << m));
        if (!c) check({tag, "_rdata"}, 64'(master_rdata), 64'(exp_rd));
        $display("txn %s: m=%0d cmd=%0d addr=0x%08h rdata=0x%08h lat=%0d",
                 tag, m, c, a, master_rdata, lat);
        master_req[m] = 1'b0;
        @(negedge clk);
        check({tag, "_ack_clr"}, 64'(master_ack), 64'd0);
        check({tag, "_sreq_cycles"}, 64'(sreq_cnt - sreq0), 64'd2);
    endtask

    initial begin
        int n;
        int cyc;
        int a0;
        int s0;
        int b0;
        master_req   = '0;
        master_addr  = '0;
        master_cmd   = '0;
        master_wdata = '0;
        tie_ack0     = 1'b0;
        aresetn      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ack",   64'(master_ack), 64'd0);
        check("rst_rdata", 64'(master_rdata), 64'd0);
        check("rst_sreq",  64'(slave_req), 64'd0);
        check("rst_saddr", 64'(slave_addr), 64'd0);
        check("rst_state", 64'(dut.r_state), 64'(IDLE));
        aresetn = 1'b1;
        @(negedge clk);

        // Single read
        do_txn(0, 32'h0000_0004, 1'b0, 32'h0, 32'h1234_5678, "rd_m0");

        // Write then read-back on M1; M0 must not be acked
        a0 = ack0_cnt;
        do_txn(1, 32'h0000_0010, 1'b1, 32'hA5A5_A5A5, 32'h0, "wr_m1");
        do_txn(1, 32'h0000_0010, 1'b0, 32'h0, 32'hA5A5_A5A5, "rb_m1");
        check("wr_rb_no_ack0", 64'(ack0_cnt - a0), 64'd0);

        // Contention from reset: grants alternate 0,1,0,1,...
        reset_dut();
        master_addr[0] = 32'h0000_0000;
        master_addr[1] = 32'h0000_0004;
        master_cmd     = 2'b00;
        master_req     = 2'b11;
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (master_ack != 2'b00) begin
                check($sformatf("cont_grant%0d", n), 64'(master_ack),
                      (n % 2 == 1) ? 64'd2 : 64'd1);
                check($sformatf("cont_rdata%0d", n), 64'(master_rdata),
                      (n % 2 == 1) ? 64'h1234_5678 : 64'hCAFE_0000);
                $display("txn cont%0d: ack=%b rdata=0x%08h", n, master_ack, master_rdata);
                n++;
            end
        end
        check("cont_count", 64'(n), 64'd6);
        master_req = 2'b00;
        repeat (2) @(negedge clk);

        // Decode filter: M0 targets another slave
        a0 = ack0_cnt;
        b0 = bad_cnt;
        master_addr[0] = BAD_ADDR;
        master_cmd[0]  = 1'b0;
        master_addr[1] = 32'h0000_0008;
        master_cmd[1]  = 1'b0;
        master_req     = 2'b11;
        cyc = 0;
        while (master_ack == 2'b00 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("dec_ack", 64'(master_ack), 64'd2);
        check("dec_rdata", 64'(master_rdata), 64'h5555_0002);
        $display("txn dec: ack=%b rdata=0x%08h", master_ack, master_rdata);
        master_req[1] = 1'b0;
        repeat (2) @(negedge clk);
        s0 = sreq_cnt;
        repeat (10) @(negedge clk);
        check("dec_no_sreq", 64'(sreq_cnt - s0), 64'd0);
        master_req[0] = 1'b0;
        check("dec_no_ack0", 64'(ack0_cnt - a0), 64'd0);
        check("dec_bad_addr", 64'(bad_cnt - b0), 64'd0);

        // Reset one cycle after grant
        @(negedge clk);
        master_addr[1] = 32'h0000_0010;
        master_cmd[1]  = 1'b0;
        master_req[1]  = 1'b1;
        @(negedge clk);
        check("mid_sreq_busy", 64'(slave_req), 64'd1);
        @(negedge clk);
        aresetn = 1'b0;
        #1;
        check("mid_rst_sreq",  64'(slave_req), 64'd0);
        check("mid_rst_ack",   64'(master_ack), 64'd0);
        check("mid_rst_state", 64'(dut.r_state), 64'(IDLE));
        check("mid_rst_ptr",   64'(dut.r_ptr), 64'd0);
        master_req[1] = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        do_txn(1, 32'h0000_0010, 1'b0, 32'h0, 32'hA5A5_A5A5, "post_rst");

`ifdef CROSS_BAR_SLAVE_TIMEOUT_EN
        begin
            int t0;
            tie_ack0 = 1'b1;
            t0 = terr_cnt;
            @(negedge clk);
            master_addr[0] = 32'h0000_0000;
            master_cmd[0]  = 1'b0;
            master_req[0]  = 1'b1;
            cyc = 0;
            while (master_ack == 2'b00 && cyc < 60) begin
                @(negedge clk);
                cyc++;
            end
            check("to_lat",   64'(cyc), 64'd18);
            check("to_ack",   64'(master_ack), 64'd1);
            check("to_rdata", 64'(master_rdata), 64'(TIMEOUT_DATA));
            $display("txn timeout: ack=%b rdata=0x%08h lat=%0d", master_ack, master_rdata, cyc);
            master_req[0] = 1'b0;
            repeat (4) @(negedge clk);
            check("to_err_pulses", 64'(terr_cnt - t0), 64'd1);
            tie_ack0 = 1'b0;
        end
`endif

        check("ack_onehot", 64'(multi_cnt), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
